// File: rtl/disc_frame_sequencer.sv
// Pixel-stream front end and prob capture stage for the Q1.15 discriminator.
// Optional thresholded decision output is_real is enabled by defining DISC_DECISION_EN.
module disc_frame_sequencer #(
    parameter int                 N_PIX         = 9,
    parameter int                 SETTLE_CYCLES = 1,
    parameter logic signed [15:0] THRESH        = 16'sh4000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [15:0]    pix_in,
    input  logic                  pix_valid,
    input  logic                  pix_last,
    output logic                  pix_ready,
    output logic [16*N_PIX-1:0]   image_flat,
    input  logic signed [15:0]    prob_in,
    output logic signed [15:0]    prob_out,
    output logic                  prob_valid,
    input  logic                  prob_ready,
    output logic                  frame_err,
`ifdef DISC_DECISION_EN
    output logic                  is_real,
`endif
    output logic [15:0]           frame_cnt
);

    typedef enum logic [1:0] {LOAD, SETTLE, OUT} state_t;

    localparam logic [3:0]  LAST_IDX    = 4'(N_PIX - 1);
    localparam logic [15:0] SETTLE_INIT = 16'(SETTLE_CYCLES);

    state_t                state_q, state_d;
    logic [3:0]            idx_q, idx_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [16*N_PIX-1:0]   img_q, img_d;
    logic signed [15:0]    prob_q, prob_d;
    logic                  pvld_q, pvld_d;
    logic                  err_q, err_d;
    logic [15:0]           fcnt_q, fcnt_d;
`ifdef DISC_DECISION_EN
    logic                  real_q, real_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        img_d   = img_q;
        prob_d  = prob_q;
        pvld_d  = pvld_q;
        err_d   = 1'b0;
        fcnt_d  = fcnt_q;
`ifdef DISC_DECISION_EN
        real_d  = real_q;
`endif
        case (state_q)
            LOAD: begin
                if (pix_valid) begin
                    img_d[{idx_q, 4'b0000} +: 16] = pix_in;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 4'd0;
                        cnt_d   = SETTLE_INIT;
                        state_d = SETTLE;
                        err_d   = ~pix_last;
                    end else if (pix_last) begin
                        // Short frame: restart at slot 0, earlier slots keep stale data.
                        idx_d = 4'd0;
                        err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q <= 16'd1) begin
                    prob_d  = prob_in;
                    pvld_d  = 1'b1;
                    state_d = OUT;
`ifdef DISC_DECISION_EN
                    real_d  = (prob_in >= THRESH);
`endif
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            OUT: begin
                if (prob_ready) begin
                    pvld_d  = 1'b0;
                    fcnt_d  = fcnt_q + 16'd1;
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            idx_q   <= 4'd0;
            cnt_q   <= 16'd0;
            img_q   <= '0;
            prob_q  <= 16'sd0;
            pvld_q  <= 1'b0;
            err_q   <= 1'b0;
            fcnt_q  <= 16'd0;
`ifdef DISC_DECISION_EN
            real_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            img_q   <= img_d;
            prob_q  <= prob_d;
            pvld_q  <= pvld_d;
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
`ifdef DISC_DECISION_EN
            real_q  <= real_d;
`endif
        end
    end

    assign pix_ready  = (state_q == LOAD) && !rst;
    assign image_flat = img_q;
    assign prob_out   = prob_q;
    assign prob_valid = pvld_q;
    assign frame_err  = err_q;
    assign frame_cnt  = fcnt_q;
`ifdef DISC_DECISION_EN
    assign is_real    = real_q;
`endif

endmodule

// File: tb/tb_disc_frame_sequencer.sv
// Directed self-checking bench for disc_frame_sequencer (N_PIX=9, SETTLE_CYCLES=1).
module tb_disc_frame_sequencer;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] pix_in;
    logic               pix_valid;
    logic               pix_last;
    logic               pix_ready;
    logic [16*9-1:0]    image_flat;
    logic signed [15:0] prob_in;
    logic signed [15:0] prob_out;
    logic               prob_valid;
    logic               prob_ready;
    logic               frame_err;
    logic [15:0]        frame_cnt;
`ifdef DISC_DECISION_EN
    logic               is_real;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    disc_frame_sequencer #(.N_PIX(9), .SETTLE_CYCLES(1), .THRESH(16'sh4000)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_last   (pix_last),
        .pix_ready  (pix_ready),
        .image_flat (image_flat),
        .prob_in    (prob_in),
        .prob_out   (prob_out),
        .prob_valid (prob_valid),
        .prob_ready (prob_ready),
        .frame_err  (frame_err),
`ifdef DISC_DECISION_EN
        .is_real    (is_real),
`endif
        .frame_cnt  (frame_cnt)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] slot(input int k);
        return image_flat[16*k +: 16];
    endfunction

    // Presents npix pixels base+k*step back-to-back; returns at the negedge of cycle 1.
    task automatic send(input logic [15:0] base, input logic [15:0] step,
                        input int npix, input int last_at);
        for (int k = 0; k < npix; k++) begin
            pix_valid = 1'b1;
            pix_in    = base + 16'(k) * step;
            pix_last  = (k == last_at);
            @(negedge clk);
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pix_in = '0; pix_valid = 1'b0; pix_last = 1'b0;
        prob_in = 16'sh3000; prob_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_pix_ready", 16'(pix_ready), 16'd0);
        chk("rst_prob_valid", 16'(prob_valid), 16'd0);
        chk("rst_prob_out", prob_out, 16'h0000);
        chk("rst_frame_cnt", frame_cnt, 16'h0000);
        chk("rst_frame_err", 16'(frame_err), 16'd0);
        chk("rst_slot0", slot(0), 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_pix_ready", 16'(pix_ready), 16'd1);

        // Basic frame 0x0100..0x0900
        send(16'h0100, 16'h0100, 9, 8);
        for (int k = 0; k < 9; k++) chk($sformatf("f1_slot%0d", k), slot(k), 16'h0100 * 16'(k + 1));
        chk("f1_c1_prob_valid", 16'(prob_valid), 16'd0);
        chk("f1_c1_pix_ready", 16'(pix_ready), 16'd0);
        @(negedge clk);
        chk("f1_c2_prob_valid", 16'(prob_valid), 16'd1);
        chk("f1_c2_prob_out", prob_out, 16'h3000);
        chk("f1_c2_frame_err", 16'(frame_err), 16'd0);
        @(negedge clk);
        chk("f1_c3_prob_valid", 16'(prob_valid), 16'd0);
        @(negedge clk);
        chk("f1_c4_frame_cnt", frame_cnt, 16'd1);
        chk("f1_c4_pix_ready", 16'(pix_ready), 16'd1);

        // Backpressure: prob_ready low for 5 cycles
        prob_ready = 1'b0; prob_in = 16'sh1234;
        send(16'h1000, 16'h0001, 9, 8);
        @(negedge clk);
        chk("bp_prob_valid", 16'(prob_valid), 16'd1);
        prob_in = 16'sh7777;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_prob_out", prob_out, 16'h1234);
            chk("bp_hold_prob_valid", 16'(prob_valid), 16'd1);
            chk("bp_hold_pix_ready", 16'(pix_ready), 16'd0);
            chk("bp_hold_frame_cnt", frame_cnt, 16'd1);
        end
        prob_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_prob_valid", 16'(prob_valid), 16'd0);
        chk("bp_rel_frame_cnt", frame_cnt, 16'd2);
        @(negedge clk);
        chk("bp_rel_pix_ready", 16'(pix_ready), 16'd1);
        chk("bp_slot8", slot(8), 16'h1008);

        // Early pix_last on 4th pixel, then a clean frame
        send(16'hA001, 16'h0001, 4, 3);
        chk("short_frame_err", 16'(frame_err), 16'd1);
        chk("short_pix_ready", 16'(pix_ready), 16'd1);
        chk("short_slot3", slot(3), 16'hA004);
        chk("short_slot4_kept", slot(4), 16'h1004);
        @(negedge clk);
        chk("short_err_clear", 16'(frame_err), 16'd0);
        chk("short_no_valid", 16'(prob_valid), 16'd0);
        prob_in = 16'sh2222;
        send(16'h0B00, 16'h0001, 9, 8);
        chk("clean_slot0", slot(0), 16'h0B00);
        chk("clean_slot8", slot(8), 16'h0B08);
        chk("clean_frame_err", 16'(frame_err), 16'd0);
        @(negedge clk);
        chk("clean_prob_out", prob_out, 16'h2222);
        chk("clean_prob_valid", 16'(prob_valid), 16'd1);
        @(negedge clk);
        @(negedge clk);
        chk("clean_frame_cnt", frame_cnt, 16'd3);

        // Ninth pixel without pix_last
        prob_in = 16'sh5555;
        send(16'h0C00, 16'h0001, 9, 99);
        chk("nolast_frame_err", 16'(frame_err), 16'd1);
        @(negedge clk);
        chk("nolast_err_clear", 16'(frame_err), 16'd0);
        chk("nolast_prob_valid", 16'(prob_valid), 16'd1);
        chk("nolast_prob_out", prob_out, 16'h5555);
        @(negedge clk);
        @(negedge clk);
        chk("nolast_frame_cnt", frame_cnt, 16'd4);

        // Reset after 5 pixels
        send(16'h0D00, 16'h0001, 5, 99);
        rst = 1'b1;
        @(negedge clk);
        chk("rst5_slot0", slot(0), 16'h0000);
        chk("rst5_frame_cnt", frame_cnt, 16'd0);
        chk("rst5_pix_ready", 16'(pix_ready), 16'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst5_pix_ready_after", 16'(pix_ready), 16'd1);

        // Reset while in OUT
        prob_ready = 1'b0; prob_in = 16'sh6666;
        send(16'h0E00, 16'h0001, 9, 8);
        @(negedge clk);
        chk("rstout_prob_valid", 16'(prob_valid), 16'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstout_prob_valid_clr", 16'(prob_valid), 16'd0);
        chk("rstout_prob_out_clr", prob_out, 16'h0000);
        chk("rstout_slot0_clr", slot(0), 16'h0000);
        rst = 1'b0; prob_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstout_no_valid", 16'(prob_valid), 16'd0);
            chk("rstout_frame_cnt", frame_cnt, 16'd0);
        end

`ifdef DISC_DECISION_EN
        prob_in = 16'sh3FFF;
        send(16'h0001, 16'h0001, 9, 8);
        @(negedge clk);
        chk("dec_3fff", 16'(is_real), 16'd0);
        @(negedge clk); @(negedge clk);
        prob_in = 16'sh4000;
        send(16'h0001, 16'h0001, 9, 8);
        @(negedge clk);
        chk("dec_4000", 16'(is_real), 16'd1);
        @(negedge clk); @(negedge clk);
        prob_in = 16'sh8000;
        send(16'h0001, 16'h0001, 9, 8);
        @(negedge clk);
        chk("dec_8000", 16'(is_real), 16'd0);
        @(negedge clk); @(negedge clk);
`endif

        // frame_cnt wrap
        force dut.fcnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.fcnt_q;
        @(negedge clk);
        chk("wrap_preload", frame_cnt, 16'hFFFF);
        send(16'h0F00, 16'h0001, 9, 8);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("wrap_frame_cnt", frame_cnt, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
